fpmult_result_checker: RTL and testbench

//  Synthesizable consumer-side checker for the pipelined FPMult unit. The operand driver pushes the

---
 rtl/fpmult_result_checker.sv | 145 ++++++++++++++
 tb/tb_fpmult_result_checker.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpmult_result_checker.sv
// Consumer-side checker for the pipelined FPMult unit: aligns expected results with FPMult
// output through a LATENCY-deep delay line, compares them, and keeps pass/fail statistics.
module fpmult_result_checker #(
  parameter int         LATENCY   = 4,
  parameter int         ULP_TOL   = 0,
  parameter logic [4:0] FLAG_MASK = 5'h1F,
  parameter int         CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             issue_valid,
  input  logic [31:0]      exp_result,
  input  logic [4:0]       exp_flags,
  input  logic [31:0]      result,
  input  logic [4:0]       flags,
  input  logic             end_req,
  output logic             chk_valid,
  output logic             chk_pass,
  output logic             any_fail,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [31:0]      first_fail_got,
  output logic [31:0]      first_fail_exp,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   issue_idx;
  logic [LATENCY-1:0] dl_valid;
  logic [CNT_W-1:0]   dl_idx   [LATENCY];
  logic [31:0]        dl_exp   [LATENCY];
  logic [4:0]         dl_flags [LATENCY];

  logic             accept;
  logic             tail_valid;
  logic [CNT_W-1:0] tail_idx;
  logic [31:0]      tail_exp;
  logic [4:0]       tail_flags;
  logic             exp_nan;
  logic             got_nan;
  logic [30:0]      mag_diff;
  logic             flags_ok;
  logic             value_ok;
  logic             match;

  assign accept     = issue_valid && (state == RUN) && !start;
  assign tail_valid = dl_valid[LATENCY-1];
  assign tail_idx   = dl_idx[LATENCY-1];
  assign tail_exp   = dl_exp[LATENCY-1];
  assign tail_flags = dl_flags[LATENCY-1];

  // Payload-only stages carry no reset; their valid bit alone decides whether they are used.
  always_ff @(posedge clk) begin
    dl_idx[0]   <= issue_idx;
    dl_exp[0]   <= exp_result;
    dl_flags[0] <= exp_flags;
    for (int i = 1; i < LATENCY; i++) begin
      dl_idx[i]   <= dl_idx[i-1];
      dl_exp[i]   <= dl_exp[i-1];
      dl_flags[i] <= dl_flags[i-1];
    end
  end

  // Magnitude compare on the low 31 bits; sign handled separately so +0/-0 differ.
  always_comb begin
    exp_nan  = (&tail_exp[30:23]) && (|tail_exp[22:0]);
    got_nan  = (&result[30:23]) && (|result[22:0]);
    mag_diff = (result[30:0] >= tail_exp[30:0]) ? (result[30:0] - tail_exp[30:0])
                                                : (tail_exp[30:0] - result[30:0]);
    flags_ok = ((flags ^ tail_flags) & FLAG_MASK) == 5'd0;
    value_ok = (exp_nan && got_nan) ||
               ((result[31] == tail_exp[31]) && (mag_diff <= 31'(ULP_TOL)));
    match    = flags_ok && value_ok;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      issue_idx      <= '0;
      dl_valid       <= '0;
      chk_valid      <= 1'b0;
      chk_pass       <= 1'b0;
      any_fail       <= 1'b0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      first_fail_idx <= '0;
      first_fail_got <= '0;
      first_fail_exp <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else if (start) begin
      state          <= RUN;
      issue_idx      <= '0;
      dl_valid       <= '0;
      chk_valid      <= 1'b0;
      chk_pass       <= 1'b0;
      any_fail       <= 1'b0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      first_fail_idx <= '0;
      first_fail_got <= '0;
      first_fail_exp <= '0;
      busy           <= 1'b1;
      done           <= 1'b0;
    end else begin
      if (accept) issue_idx <= issue_idx + 1'b1;
      dl_valid[0] <= accept;
      for (int i = 1; i < LATENCY; i++) dl_valid[i] <= dl_valid[i-1];

      chk_valid <= tail_valid;
      chk_pass  <= tail_valid && match;
      if (tail_valid) begin
        if (match) begin
          if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
        end else begin
          if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
          any_fail <= 1'b1;
          if (!any_fail) begin
            first_fail_idx <= tail_idx;
            first_fail_got <= result;
            first_fail_exp <= tail_exp;
          end
        end
      end

      case (state)
        RUN: if (end_req) state <= DRAIN;
        DRAIN: begin
          if (dl_valid == '0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpmult_result_checker.sv
// Bench for fpmult_result_checker: two instances (different tolerance, flag mask and counter width)
// share one stimulus stream and are checked every cycle against a queue-based reference model.
module tb_fpmult_result_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, issue_valid = 1'b0, end_req = 1'b0;
  logic [31:0] exp_result = '0, result = '0;
  logic [4:0]  exp_flags = '0, flags = '0;

  logic        a_chk_valid, a_chk_pass, a_any_fail, a_busy, a_done;
  logic [15:0] a_pass_cnt, a_fail_cnt, a_ff_idx;
  logic [31:0] a_ff_got, a_ff_exp;
  logic        b_chk_valid, b_chk_pass, b_any_fail, b_busy, b_done;
  logic [3:0]  b_pass_cnt, b_fail_cnt, b_ff_idx;
  logic [31:0] b_ff_got, b_ff_exp;

  always #5 clk = ~clk;

  fpmult_result_checker #(.LATENCY(4), .ULP_TOL(0), .FLAG_MASK(5'h1F), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .start(start), .issue_valid(issue_valid), .exp_result(exp_result),
    .exp_flags(exp_flags), .result(result), .flags(flags), .end_req(end_req),
    .chk_valid(a_chk_valid), .chk_pass(a_chk_pass), .any_fail(a_any_fail),
    .pass_cnt(a_pass_cnt), .fail_cnt(a_fail_cnt), .first_fail_idx(a_ff_idx),
    .first_fail_got(a_ff_got), .first_fail_exp(a_ff_exp), .busy(a_busy), .done(a_done));

  fpmult_result_checker #(.LATENCY(4), .ULP_TOL(1), .FLAG_MASK(5'h1E), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .start(start), .issue_valid(issue_valid), .exp_result(exp_result),
    .exp_flags(exp_flags), .result(result), .flags(flags), .end_req(end_req),
    .chk_valid(b_chk_valid), .chk_pass(b_chk_pass), .any_fail(b_any_fail),
    .pass_cnt(b_pass_cnt), .fail_cnt(b_fail_cnt), .first_fail_idx(b_ff_idx),
    .first_fail_got(b_ff_got), .first_fail_exp(b_ff_exp), .busy(b_busy), .done(b_done));

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    int          idx;
    logic [31:0] exp;
    logic [4:0]  ef;
  } pend_t;

  pend_t       pend[$];
  int          cyc = 0;
  int          m_mode;          // 0 idle, 1 run, 2 drain, 3 done
  int          m_idx;
  bit          m_cv;
  bit          m_cp   [2];
  int          m_pass [2];
  int          m_fail [2];
  bit          m_any  [2];
  int          m_ffidx[2];
  logic [31:0] m_ffgot[2];
  logic [31:0] m_ffexp[2];
  int          tol    [2] = '{0, 1};
  logic [4:0]  msk    [2] = '{5'h1F, 5'h1E};
  int          cmax   [2] = '{65535, 15};

  logic [31:0] sched_got[4096];
  logic [4:0]  sched_gf [4096];

  int n_pass = 0, n_fail = 0, n_total = 0;

  function automatic void model_reset();
    pend.delete();
    m_mode = 0;
    m_idx  = 0;
    m_cv   = 0;
    for (int i = 0; i < 2; i++) begin
      m_cp[i] = 0; m_pass[i] = 0; m_fail[i] = 0; m_any[i] = 0;
      m_ffidx[i] = 0; m_ffgot[i] = '0; m_ffexp[i] = '0;
    end
  endfunction

  function automatic bit golden_match(input logic [31:0] e, input logic [31:0] g,
                                      input logic [4:0] ef, input logic [4:0] gf,
                                      input int t, input logic [4:0] m);
    longint d;
    if (((ef ^ gf) & m) != 5'd0) return 0;
    if (e[30:23] == 8'hFF && e[22:0] != 0 && g[30:23] == 8'hFF && g[22:0] != 0) return 1;
    if (e[31] != g[31]) return 0;
    d = longint'(e[30:0]) - longint'(g[30:0]);
    if (d < 0) d = -d;
    return d <= longint'(t);
  endfunction

  function automatic void model_edge();
    pend_t p;
    bit    empty;
    bit    ok;
    if (!rst) begin model_reset(); return; end
    if (start) begin model_reset(); m_mode = 1; return; end
    empty = (pend.size() == 0);
    m_cv = 0;
    m_cp[0] = 0; m_cp[1] = 0;
    if (pend.size() != 0 && pend[0].due == cyc) begin
      p = pend.pop_front();
      m_cv = 1;
      for (int i = 0; i < 2; i++) begin
        ok = golden_match(p.exp, result, p.ef, flags, tol[i], msk[i]);
        m_cp[i] = ok;
        if (ok) begin
          if (m_pass[i] < cmax[i]) m_pass[i]++;
        end else begin
          if (m_fail[i] < cmax[i]) m_fail[i]++;
          if (!m_any[i]) begin
            m_ffidx[i] = p.idx % (cmax[i] + 1);
            m_ffgot[i] = result;
            m_ffexp[i] = p.exp;
          end
          m_any[i] = 1;
        end
      end
    end
    if (issue_valid && m_mode == 1) begin
      pend.push_back('{cyc + 4, m_idx, exp_result, exp_flags});
      m_idx++;
    end
    if (m_mode == 1 && end_req) m_mode = 2;
    else if (m_mode == 2 && empty) m_mode = 3;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_inst(input int i, input string nm, input logic cv, input logic cp,
                            input logic af, input logic [31:0] pc, input logic [31:0] fc,
                            input logic [31:0] fi, input logic [31:0] fg, input logic [31:0] fe,
                            input logic bs, input logic dn);
    chk({nm, "_chk_valid"}, 32'(cv), 32'(m_cv));
    if (m_cv) chk({nm, "_chk_pass"}, 32'(cp), 32'(m_cp[i]));
    else if (!rst) chk({nm, "_chk_pass_rst"}, 32'(cp), 32'd0);
    chk({nm, "_any_fail"}, 32'(af), 32'(m_any[i]));
    chk({nm, "_pass_cnt"}, pc, 32'(m_pass[i]));
    chk({nm, "_fail_cnt"}, fc, 32'(m_fail[i]));
    chk({nm, "_ff_idx"}, fi, 32'(m_ffidx[i]));
    chk({nm, "_ff_got"}, fg, m_ffgot[i]);
    chk({nm, "_ff_exp"}, fe, m_ffexp[i]);
    chk({nm, "_busy"}, 32'(bs), 32'(m_mode == 1 || m_mode == 2));
    chk({nm, "_done"}, 32'(dn), 32'(m_mode == 3));
  endtask

  task automatic check_all();
    check_inst(0, "a", a_chk_valid, a_chk_pass, a_any_fail, 32'(a_pass_cnt), 32'(a_fail_cnt),
               32'(a_ff_idx), a_ff_got, a_ff_exp, a_busy, a_done);
    check_inst(1, "b", b_chk_valid, b_chk_pass, b_any_fail, 32'(b_pass_cnt), 32'(b_fail_cnt),
               32'(b_ff_idx), b_ff_got, b_ff_exp, b_busy, b_done);
  endtask

  // One clock cycle: present the scheduled FPMult result, clock, update model, check.
  task automatic step();
    result = sched_got[cyc % 4096];
    flags  = sched_gf[cyc % 4096];
    sched_got[cyc % 4096] = $urandom;
    sched_gf[cyc % 4096]  = 5'($urandom_range(0, 31));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
    cyc++;
    start = 0; end_req = 0; issue_valid = 0;
  endtask

  task automatic issue(input logic [31:0] e, input logic [4:0] ef,
                       input logic [31:0] g, input logic [4:0] gf);
    issue_valid = 1;
    exp_result  = e;
    exp_flags   = ef;
    sched_got[(cyc + 4) % 4096] = g;
    sched_gf[(cyc + 4) % 4096]  = gf;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] e, g;
    logic [4:0]  ef, gf;
    int          c;
    for (int i = 0; i < 4096; i++) begin
      sched_got[i] = $urandom;
      sched_gf[i]  = 5'($urandom_range(0, 31));
    end
    model_reset();
    @(negedge clk);
    check_all();
    repeat (2) step();
    rst = 1;
    repeat (2) step();

    // single matching issue
    start = 1; step();
    issue(32'hBF831041, 5'h00, 32'hBF831041, 5'h00);
    repeat (6) step();
    chk("t1_pass_cnt", 32'(a_pass_cnt), 32'd1);

    // ten back-to-back, third result one ULP off
    start = 1; step();
    for (int k = 0; k < 10; k++)
      issue(32'hBF831041, 5'h00, (k == 2) ? 32'hBF831042 : 32'hBF831041, 5'h00);
    repeat (6) step();
    chk("t2_a_pass", 32'(a_pass_cnt), 32'd9);
    chk("t2_a_fail", 32'(a_fail_cnt), 32'd1);
    chk("t2_a_ffidx", 32'(a_ff_idx), 32'd2);
    chk("t2_a_ffgot", a_ff_got, 32'hBF831042);
    chk("t2_a_ffexp", a_ff_exp, 32'hBF831041);
    chk("t2_b_pass", 32'(b_pass_cnt), 32'd10);

    // exponent boundary, signed zero, NaN payloads, flag masking
    start = 1; step();
    issue(32'h3F800000, 5'h00, 32'h3F7FFFFF, 5'h00);
    issue(32'h00000000, 5'h00, 32'h80000000, 5'h00);
    issue(32'h7FC00000, 5'h00, 32'hFFC00001, 5'h00);
    issue(32'h3F800000, 5'h01, 32'h3F800000, 5'h00);
    issue(32'h3F800000, 5'h12, 32'h3F800000, 5'h12);
    repeat (6) step();
    chk("t4_a_pass", 32'(a_pass_cnt), 32'd2);
    chk("t4_a_fail", 32'(a_fail_cnt), 32'd3);
    chk("t4_b_pass", 32'(b_pass_cnt), 32'd4);
    chk("t4_b_ffgot", b_ff_got, 32'h80000000);

    // drain with three in flight; issue during drain is dropped
    start = 1; step();
    for (int k = 0; k < 3; k++) begin
      e = $urandom;
      issue(e, 5'h00, e, 5'h00);
    end
    end_req = 1; step();
    issue(32'h40000000, 5'h00, 32'h12345678, 5'h00);
    repeat (8) step();
    chk("t5_done", 32'(a_done), 32'd1);
    chk("t5_pass", 32'(a_pass_cnt), 32'd3);
    start = 1; step();
    chk("t5_restart_pass", 32'(a_pass_cnt), 32'd0);

    // randomized traffic
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        step();
      end else begin
        e  = $urandom;
        ef = 5'($urandom_range(0, 31));
        c  = int'($urandom_range(0, 5));
        case (c)
          0: g = e;
          1: g = e + 32'd1;
          2: g = e - 32'd1;
          3: g = $urandom;
          4: begin
            e = {e[31], 8'hFF, e[22:0] | 23'd1};
            g = $urandom;
            g = {g[31], 8'hFF, g[22:0] | 23'd1};
          end
          default: g = e ^ 32'h80000000;
        endcase
        gf = ($urandom_range(0, 3) == 0) ? (ef ^ (5'd1 << $urandom_range(0, 4))) : ef;
        issue(e, ef, g, gf);
      end
    end
    end_req = 1; step();
    repeat (8) step();

    // counter saturation on the narrow instance
    start = 1; step();
    for (int k = 0; k < 20; k++) issue(32'h3F800000, 5'h00, 32'h3F800000, 5'h00);
    repeat (6) step();
    chk("t6_b_sat", 32'(b_pass_cnt), 32'hF);
    chk("t6_a_pass", 32'(a_pass_cnt), 32'd20);

    // asynchronous reset with results in flight
    start = 1; step();
    for (int k = 0; k < 3; k++) issue(32'h3F800000, 5'h00, 32'h3F800000, 5'h00);
    #2 rst = 0;
    #1 model_reset();
    check_all();
    repeat (2) step();
    rst = 1;
    repeat (10) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
